// File: rtl/cl_memdut_scrubber.sv
// cl_memdut_scrubber: zero-fills DDR [0, MAX_ADDR) with AXI write bursts; define SCRB_ERR_STOP_EN to stop on a bad bresp.
module cl_memdut_scrubber #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH = 16,
  parameter int ADDR_WIDTH = 64,
  parameter int BURST_LEN = 64,
  parameter int SCRB_ID = 0,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(64'h4_0000_0000)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scrb_enable,
  output logic [ADDR_WIDTH-1:0]   scrb_addr,
  output logic [2:0]              scrb_state,
  output logic                    scrb_done,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ID_WIDTH-1:0]     wid,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);
  localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, DATA = 3'd2, RESP = 3'd3, DONE = 3'd4, ERR = 3'd5;
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  if (MAX_ADDR == '0 || BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_cfg
    $error("cl_memdut_scrubber: MAX_ADDR must be nonzero and BURST_LEN within 1..256");
  end

  logic [2:0] state;
  logic [7:0] beat;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic b_err, unused;

`ifdef SCRB_ERR_STOP_EN
  assign b_err = |bresp;
  assign unused = ^bid;
`else
  assign b_err = 1'b0;
  assign unused = ^{bid, bresp};
`endif

  assign next_addr = scrb_addr + BURST_BYTES;
  assign scrb_state = state;
  assign scrb_done = state == DONE || state == ERR;
  assign awid = ID_WIDTH'(SCRB_ID);
  assign wid = ID_WIDTH'(SCRB_ID);
  assign awaddr = scrb_addr;
  assign awlen = LAST_BEAT;
  assign awsize = 3'($clog2(DATA_WIDTH / 8));
  assign awvalid = state == ADDR;
  assign wvalid = state == DATA;
  assign wdata = '0;
  assign wstrb = '1;
  assign wlast = wvalid && beat == LAST_BEAT;
  assign bready = state == RESP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      scrb_addr <= '0;
      beat <= '0;
    end else begin
      case (state)
        IDLE: if (scrb_enable) begin
          state <= ADDR;
          scrb_addr <= '0;
        end
        ADDR: if (awready) begin
          state <= DATA;
          beat <= '0;
        end
        DATA: if (wready) begin
          beat <= beat + 8'd1;
          if (wlast) state <= RESP;
        end
        RESP: if (bvalid) begin
          if (b_err) state <= ERR;
          else begin
            scrb_addr <= next_addr;
            state <= next_addr == MAX_ADDR ? DONE : scrb_enable ? ADDR : IDLE;
          end
        end
        DONE, ERR: if (!scrb_enable) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cl_memdut_scrubber.sv
// tb_cl_memdut_scrubber: directed scrub scenarios against a cycle-by-cycle AXI write-side model and responding slave.
module tb_cl_memdut_scrubber;
  localparam int BL = 64;
  localparam logic [63:0] MAXA = 64'h3000;
  localparam logic [63:0] BB = 64'h1000;

  logic clk = 1'b0, rst = 1'b1, scrb_enable = 1'b0;
  logic [63:0] scrb_addr;
  logic [2:0] scrb_state;
  logic scrb_done;
  logic [15:0] awid, wid;
  logic [15:0] bid = '0;
  logic [63:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic awvalid, wlast, wvalid, bready;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [511:0] wdata;
  logic [63:0] wstrb;
  logic [1:0] bresp = 2'b00;

  always #5 clk = ~clk;

  cl_memdut_scrubber #(.MAX_ADDR(MAXA), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .scrb_enable(scrb_enable),
    .scrb_addr(scrb_addr), .scrb_state(scrb_state), .scrb_done(scrb_done),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0, passes = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // model of the write side and the responding slave
  logic [63:0] exp_next = '0, prev_awaddr = '0, err_addr = '0;
  logic [63:0] aw_log[$], b_base[$];
  bit aw_out = 0, prev_stall = 0, rand_stall = 0, err_en = 0;
  int beats = 0, pending_b = 0, aw_hold = 0;
  int aw_count = 0, beat_count = 0, wlast_count = 0, b_count = 0;

  initial forever begin
    @(negedge clk);
    if (prev_stall) begin
      check("aw_hold_valid", 64'(awvalid), 64'(1));
      check("aw_hold_addr", awaddr, prev_awaddr);
    end
    if (awvalid) begin
      check("aw_no_overlap", 64'(aw_out || pending_b != 0), 64'(0));
      check("awaddr", awaddr, exp_next);
      check("awlen", 64'(awlen), 64'(BL - 1));
      check("awsize", 64'(awsize), 64'(6));
      check("awid", 64'(awid), 64'(0));
    end
    if (wvalid) begin
      check("w_after_aw", 64'(aw_out), 64'(1));
      check("wdata_zero", 64'(|wdata), 64'(0));
      check("wstrb_ones", 64'(&wstrb), 64'(1));
      check("wlast", 64'(wlast), 64'(beats == BL - 1));
      check("wid", 64'(wid), 64'(0));
    end
    awready = aw_hold == 0;
    if (aw_hold > 0 && awvalid) aw_hold--;
    wready = rand_stall ? 1'($urandom_range(1)) : 1'b1;
    bvalid = pending_b > 0 && (rand_stall ? $urandom_range(1) == 1 : 1'b1);
    bresp = (bvalid && err_en && b_base.size() > 0 && b_base[0] == err_addr) ? 2'b10 : 2'b00;
    if (bvalid) check("bready", 64'(bready), 64'(1));
    prev_stall = awvalid && !awready;
    prev_awaddr = awaddr;
    if (rst) begin
      aw_out = 0; beats = 0; pending_b = 0; prev_stall = 0; bvalid = 1'b0;
      b_base.delete();
    end else begin
      if (awvalid && awready) begin
        aw_out = 1; beats = 0; aw_count++;
        aw_log.push_back(awaddr); b_base.push_back(awaddr);
        exp_next += BB;
      end
      if (wvalid && wready) begin
        beat_count++;
        if (wlast) wlast_count++;
        beats++;
        if (beats == BL) begin aw_out = 0; pending_b++; end
      end
      if (bvalid && bready) begin
        pending_b--; b_count++;
        b_base.delete(0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start();
    aw_count = 0; beat_count = 0; wlast_count = 0; b_count = 0;
    aw_log.delete();
    exp_next = '0;
    scrb_enable = 1'b1;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!scrb_done && n < budget) begin cyc(1); n++; end
    check("done_timeout", 64'(scrb_done), 64'(1));
  endtask

  task automatic full_run_check(input string t);
    check({t, "_state"}, 64'(scrb_state), 64'(4));
    check({t, "_addr"}, scrb_addr, MAXA);
    check({t, "_done"}, 64'(scrb_done), 64'(1));
    check({t, "_aw_count"}, 64'(aw_count), 64'(3));
    check({t, "_beats"}, 64'(beat_count), 64'(192));
    check({t, "_wlasts"}, 64'(wlast_count), 64'(3));
    check({t, "_bresps"}, 64'(b_count), 64'(3));
    if (aw_log.size() == 3) begin
      check({t, "_aw0"}, aw_log[0], 64'h0);
      check({t, "_aw1"}, aw_log[1], 64'h1000);
      check({t, "_aw2"}, aw_log[2], 64'h2000);
    end
  endtask

  task automatic stop();
    scrb_enable = 1'b0;
    cyc(1);
    check("exit_state", 64'(scrb_state), 64'(0));
    check("exit_done", 64'(scrb_done), 64'(0));
    cyc(1);
  endtask

  initial begin
    int n;
    cyc(3);
    @(negedge clk);
    check("rst_state", 64'(scrb_state), 64'(0));
    check("rst_addr", scrb_addr, 64'h0);
    check("rst_done", 64'(scrb_done), 64'(0));
    check("rst_valids", 64'({awvalid, wvalid, wlast, bready}), 64'(0));
    cyc(1);
    rst = 1'b0;
    cyc(2);
    check("idle_no_aw", 64'(aw_count), 64'(0));

    // 1: plain full run, slave always ready
    start();
    wait_done(400, n);
    check("t1_throughput", 64'(n <= 3 * (BL + 3) + 2), 64'(1));
    full_run_check("t1");
    cyc(3);
    check("t1_done_hold_state", 64'(scrb_state), 64'(4));
    check("t1_done_hold_addr", scrb_addr, MAXA);
    check("t1_no_extra_aw", 64'(aw_count), 64'(3));
    stop();

    // 2: awready held low for 5 cycles on the first AW
    aw_hold = 5;
    start();
    wait_done(400, n);
    check("t2_stall_used", 64'(aw_hold), 64'(0));
    full_run_check("t2");
    stop();

    // 3: random wready/bvalid stalls
    rand_stall = 1;
    start();
    wait_done(3000, n);
    full_run_check("t3");
    rand_stall = 0;
    stop();

    // 4: drop enable at beat 10 of burst 2
    start();
    n = 0;
    while (!(aw_count == 2 && beats >= 10) && n < 400) begin cyc(1); n++; end
    check("t4_reach_beat10", 64'(aw_count == 2 && beats >= 10), 64'(1));
    scrb_enable = 1'b0;
    n = 0;
    while (b_count < 2 && n < 400) begin cyc(1); n++; end
    cyc(2);
    check("t4_state", 64'(scrb_state), 64'(0));
    check("t4_addr", scrb_addr, 64'h2000);
    check("t4_done", 64'(scrb_done), 64'(0));
    check("t4_beats", 64'(beat_count), 64'(128));
    check("t4_wlasts", 64'(wlast_count), 64'(2));
    cyc(5);
    check("t4_no_aw_idle", 64'(aw_count), 64'(2));
    start();
    wait_done(400, n);
    full_run_check("t4r");
    stop();

    // 5: reset in the middle of a data phase
    start();
    n = 0;
    while (beat_count < 20 && n < 400) begin cyc(1); n++; end
    check("t5_in_data", 64'(wvalid), 64'(1));
    rst = 1'b1;
    scrb_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_state", 64'(scrb_state), 64'(0));
    check("t5_wvalid", 64'(wvalid), 64'(0));
    check("t5_addr", scrb_addr, 64'h0);
    check("t5_done", 64'(scrb_done), 64'(0));
    cyc(1);
    rst = 1'b0;
    cyc(1);
    start();
    wait_done(400, n);
    full_run_check("t5r");
    stop();

    // 6: SLVERR on the burst at 0x1000
    err_en = 1;
    err_addr = 64'h1000;
    start();
    wait_done(400, n);
    cyc(5);
`ifdef SCRB_ERR_STOP_EN
    check("t6_state", 64'(scrb_state), 64'(5));
    check("t6_done", 64'(scrb_done), 64'(1));
    check("t6_addr", scrb_addr, 64'h1000);
    check("t6_aw_count", 64'(aw_count), 64'(2));
`else
    full_run_check("t6");
`endif
    err_en = 0;
    stop();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
